// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer.
//   state_t        : sequencer state encoding (also the 3-bit `state` output)
//   OP_* / FN_* /  : opcode, funct and REGIMM rt constants used by the
//   RT_*             instruction class decoder
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;  // first of the I-type ALU range
  localparam logic [5:0] OP_ANDI    = 6'h0C;  // first zero-extended immediate op
  localparam logic [5:0] OP_LUI     = 6'h0F;  // last of both ranges above
  localparam logic [5:0] OP_LB      = 6'h20;  // first load
  localparam logic [5:0] OP_LWR     = 6'h26;  // last load
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes that write no GPR
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  // REGIMM link variants (write $ra)
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  function automatic logic is_zero_ext_op(input logic [5:0] op);
    return op inside {[OP_ANDI:OP_LUI]};
  endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational classification of the latched instruction word.
//   instr    : instruction register contents
//   is_load  : opcode 0x20-0x26
//   is_store : opcode 0x28, 0x29, 0x2B
//   has_dest : instruction writes a GPR in WB
//   ext_zero : 1 selects the zero-extended immediate (ANDI/ORI/XORI/LUI)
module instr_class_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_load,
  output logic        is_store,
  output logic        has_dest,
  output logic        ext_zero
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  assign is_load  = op inside {[OP_LB:OP_LWR]};
  assign is_store = op inside {OP_SB, OP_SH, OP_SW};
  assign ext_zero = is_zero_ext_op(op);

  always_comb begin
    has_dest = 1'b0;
    if (op == OP_SPECIAL)
      has_dest = !(funct inside {FN_JR, FN_MTHI, FN_MTLO, [FN_MULT:FN_DIVU]});
    else if (op inside {[OP_ADDI:OP_LUI]})
      has_dest = 1'b1;
    else if (is_load)
      has_dest = 1'b1;
    else if (op == OP_JAL)
      has_dest = 1'b1;
    else if (op == OP_REGIMM)
      has_dest = rt inside {RT_BLTZAL, RT_BGEZAL};
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH -> EXEC -> [MEM] -> WB, halting when the
// PC reaches 0.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   waitrequest  : memory stall, honoured in FETCH and MEM
//   readdata     : instruction word during FETCH
//   pc_zero      : PC == 0, checked in FETCH (priority over waitrequest)
//   state        : current state encoding
//   active       : 0 once halted
//   instr        : instruction register
//   ext_zero     : immediate extender select (1 = zero extend)
//   read, write  : memory strobes
//   ir_write, pc_write, reg_write : datapath enables
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        pc_zero,
  output logic [2:0]  state,
  output logic        active,
  output logic [31:0] instr,
  output logic        ext_zero,
  output logic        read,
  output logic        write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write
);

  state_t cur, nxt;
  logic   ir_load;
  logic   is_load, is_store, has_dest;

  instr_class_decoder u_decoder (
    .instr    (instr),
    .is_load  (is_load),
    .is_store (is_store),
    .has_dest (has_dest),
    .ext_zero (ext_zero)
  );

  assign ir_load = (cur == S_FETCH) && !pc_zero && !waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= RESET_STATE;
      instr <= '0;
    end else begin
      cur <= nxt;
      if (ir_load)
        instr <= readdata;
    end
  end

  always_comb begin
    nxt       = cur;
    read      = 1'b0;
    write     = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    case (cur)
      S_FETCH: begin
        if (pc_zero) begin
          nxt = S_HALT;
        end else begin
          read     = 1'b1;
          ir_write = !waitrequest;
          if (!waitrequest)
            nxt = S_EXEC;
        end
      end
      S_EXEC:
        nxt = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        read  = is_load;
        write = is_store;
        if (!waitrequest)
          nxt = S_WB;
      end
      S_WB: begin
        pc_write  = 1'b1;
        reg_write = has_dest;
        nxt       = S_FETCH;
      end
      S_HALT:
        nxt = S_HALT;
      default:
        nxt = S_HALT;
    endcase
    // Strobes are combinational, so gate them here to keep them quiet for
    // the whole reset pulse, not just after the register clears.
    if (reset) begin
      read      = 1'b0;
      write     = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state  = cur;
  assign active = cur inside {S_FETCH, S_EXEC, S_MEM, S_WB};

endmodule

// File: tb/tb_mips_seq_ctrl.sv
module tb_mips_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        pc_zero;
  logic [2:0]  state;
  logic        active;
  logic [31:0] instr;
  logic        ext_zero;
  logic        read, write, ir_write, pc_write, reg_write;

  mips_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .pc_zero     (pc_zero),
    .state       (state),
    .active      (active),
    .instr       (instr),
    .ext_zero    (ext_zero),
    .read        (read),
    .write       (write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle behaviour of one instruction
  typedef struct {
    int st;
    bit rd, wr, irw, pcw, rgw;
    bit wt;   // waitrequest to drive in this cycle
  } cyc_t;

  logic [31:0] model_ir;

  // ---------- reference classification (from the ISA rules) ----------
  function automatic bit m_load(input logic [31:0] i);
    int op = int'(i[31:26]);
    return op >= 32 && op <= 38;
  endfunction

  function automatic bit m_store(input logic [31:0] i);
    int op = int'(i[31:26]);
    return op == 40 || op == 41 || op == 43;
  endfunction

  function automatic bit m_dest(input logic [31:0] i);
    int op = int'(i[31:26]);
    int f  = int'(i[5:0]);
    int rt = int'(i[20:16]);
    if (op == 0)  return !(f == 8 || f == 17 || f == 19 || (f >= 24 && f <= 27));
    if (op >= 8 && op <= 15) return 1;
    if (m_load(i)) return 1;
    if (op == 3)  return 1;
    if (op == 1)  return rt == 16 || rt == 17;
    return 0;
  endfunction

  function automatic bit m_zext(input logic [31:0] i);
    int op = int'(i[31:26]);
    return op >= 12 && op <= 15;
  endfunction

  // Build the whole cycle-by-cycle trace of one instruction.
  task automatic build(input logic [31:0] i, input int fw, input int mw,
                       output cyc_t q[$]);
    cyc_t e;
    q = {};
    for (int k = 0; k < fw; k++) begin
      e = '{st:0, rd:1, wr:0, irw:0, pcw:0, rgw:0, wt:1}; q.push_back(e);
    end
    e = '{st:0, rd:1, wr:0, irw:1, pcw:0, rgw:0, wt:0}; q.push_back(e);
    e = '{st:1, rd:0, wr:0, irw:0, pcw:0, rgw:0, wt:0}; q.push_back(e);
    if (m_load(i) || m_store(i)) begin
      for (int k = 0; k < mw; k++) begin
        e = '{st:2, rd:m_load(i), wr:m_store(i), irw:0, pcw:0, rgw:0, wt:1};
        q.push_back(e);
      end
      e = '{st:2, rd:m_load(i), wr:m_store(i), irw:0, pcw:0, rgw:0, wt:0};
      q.push_back(e);
    end
    e = '{st:3, rd:0, wr:0, irw:0, pcw:1, rgw:m_dest(i), wt:0}; q.push_back(e);
  endtask

  // Runs one instruction from FETCH back to FETCH, checking every cycle.
  // Entered and left at posedge+1.
  task automatic run_trace(input logic [31:0] i, input int fw, input int mw,
                           input string tag);
    cyc_t q[$];
    logic [9:0] obs, exp;
    build(i, fw, mw, q);
    foreach (q[n]) begin
      waitrequest = (q[n].st == 0 || q[n].st == 2) ? q[n].wt : 1'($urandom);
      pc_zero     = (q[n].st == 0) ? 1'b0 : 1'($urandom);
      readdata    = (q[n].st == 0) ? i : $urandom;
      #1;
      obs = {state, read, write, ir_write, pc_write, reg_write, active, ext_zero};
      exp = {3'(q[n].st), q[n].rd, q[n].wr, q[n].irw, q[n].pcw, q[n].rgw,
             1'b1, m_zext(model_ir)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d {st,rd,wr,irw,pcw,rgw,act,ez} got %b want %b (instr %h)",
                 tag, n, obs, exp, i);
      end
      checks++;
      if (instr !== model_ir) begin
        errors++;
        $display("FAIL %s cyc%0d instr got %h want %h", tag, n, instr, model_ir);
      end
      @(posedge clk); #1;
      if (q[n].irw) model_ir = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; waitrequest = 1'b0; pc_zero = 1'b0; readdata = $urandom;
    @(posedge clk); #1;
    checks++;
    if ({state, active, ext_zero, read, write, ir_write, pc_write, reg_write} !== 10'b000_1_0_00000
        || instr !== 32'h0) begin
      errors++;
      $display("FAIL reset state=%0d act=%b ez=%b strobes=%b%b%b%b%b instr=%h want 0/1/0/00000/0",
               state, active, ext_zero, read, write, ir_write, pc_write, reg_write, instr);
    end
    reset = 1'b0;
    model_ir = '0;
  endtask

  task automatic test_addiu();
    run_trace(32'h24010001, 0, 0, "addiu");
  endtask

  task automatic test_ori();
    logic [31:0] sel;
    run_trace(32'h34018001, 0, 0, "ori");
    waitrequest = 1'b1; pc_zero = 1'b0; #1;
    sel = ext_zero ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    checks++;
    if (sel !== 32'h00008001) begin
      errors++;
      $display("FAIL ori_imm selected %h want 00008001", sel);
    end
    @(posedge clk); #1;   // stalled fetch, still in FETCH
  endtask

  task automatic test_mem_ops();
    run_trace(32'h8C220004, 0, 2, "lw");
    run_trace(32'hAC220004, 1, 0, "sw");
    run_trace(32'h03E00008, 0, 0, "jr");
    run_trace(32'h0C000010, 2, 0, "jal");
    run_trace(32'h04110003, 0, 0, "bgezal");
    run_trace(32'h04010003, 0, 0, "bgez");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [19];
    logic [5:0] fns [8];
    logic [31:0] i;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D,
            6'h0F, 6'h10, 6'h20, 6'h23, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B};
    fns = '{6'h08, 6'h09, 6'h11, 6'h13, 6'h18, 6'h1B, 6'h1C, 6'h21};
    for (int n = 0; n < 40; n++) begin
      i = $urandom;
      i[31:26] = ops[$urandom_range(0, 18)];
      if ($urandom_range(0, 1) == 1) i[5:0] = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) i[20:16] = 5'h10 + 5'($urandom_range(0, 1));
      run_trace(i, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_reset_mid_mem();
    waitrequest = 1'b0; pc_zero = 1'b0; readdata = 32'h8C220004;
    @(posedge clk); #1;               // -> EXEC
    @(posedge clk); #1;               // -> MEM
    waitrequest = 1'b1; #1;
    checks++;
    if (state !== 3'd2 || read !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre state=%0d read=%b want 2/1", state, read);
    end
    #2 reset = 1'b1; #1;
    checks++;
    if ({state, read, write, ir_write, pc_write, reg_write, active} !== 9'b000_00000_1
        || instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid state=%0d strobes=%b%b%b%b%b act=%b instr=%h want 0/00000/1/0",
               state, read, write, ir_write, pc_write, reg_write, active, instr);
    end
    @(posedge clk); #1;
    checks++;
    if ({state, read, write, ir_write, pc_write, reg_write} !== 8'b000_00000) begin
      errors++;
      $display("FAIL rst_hold state=%0d strobes=%b%b%b%b%b want 0/00000",
               state, read, write, ir_write, pc_write, reg_write);
    end
    reset = 1'b0;
    model_ir = '0;
    run_trace(32'h24010001, 1, 0, "restart");
  endtask

  task automatic test_halt();
    pc_zero = 1'b1; waitrequest = 1'($urandom); readdata = $urandom; #1;
    checks++;
    if (state !== 3'd0 || read !== 1'b0 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry state=%0d read=%b irw=%b want 0/0/0", state, read, ir_write);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 11; n++) begin
      pc_zero = 1'($urandom); waitrequest = 1'($urandom); readdata = $urandom; #1;
      checks++;
      if ({state, active, read, write, ir_write, pc_write, reg_write} !== 9'b100_0_00000) begin
        errors++;
        $display("FAIL halt cyc%0d state=%0d act=%b strobes=%b%b%b%b%b want 4/0/00000",
                 n, state, active, read, write, ir_write, pc_write, reg_write);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; waitrequest = 1'b0; pc_zero = 1'b0; readdata = '0;
    model_ir = '0;
    test_reset();
    test_addiu();
    test_ori();
    test_mem_ops();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
